// File: rtl/cdc_rx_4phase_pkg.sv
// Shared types and limits for the 4-phase bundled-data receiver and its sender-side peer.
package cdc_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACKED    = 2'd1,
        WAIT_LOW = 2'd2
    } rx_state_t;

endpackage

// File: rtl/cdc_rx_4phase_if.sv
// Handshake and consumer-side bus of the 4-phase receiver; slave is the receiver's view.
interface cdc_rx_4phase_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                  req;
    logic [DATA_WIDTH-1:0] input_rx;
    logic                  ack;
    logic                  rx_pulse;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_W-1:0]      fifo_count;
    logic                  stall;

    modport master (
        output req, input_rx, out_ready,
        input  ack, rx_pulse, out_data, out_valid, fifo_count, stall
    );

    modport slave (
        input  req, input_rx, out_ready,
        output ack, rx_pulse, out_data, out_valid, fifo_count, stall
    );

endinterface

// File: rtl/sync_chain.sv
// Plain flop-chain synchronizer; WIDTH bits are synchronized independently.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cdc_rx_4phase.sv
// 4-phase bundled-data receiver: synchronizes req, captures input_rx once per handshake
// into a small register FIFO and returns a registered ack.
//
// state    | meaning
// IDLE     | waiting for synchronized req; captures when the FIFO has room
// ACKED    | word captured, ack high until synchronized req falls
// WAIT_LOW | one-cycle guard after ack falls so a stale req_s cannot recapture
import cdc_pkg::*;

module cdc_rx_4phase #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    cdc_rx_4phase_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("cdc_rx_4phase: SYNC_STAGES out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cdc_rx_4phase: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                  req_s;
    logic                  req_s_q;
    rx_state_t             state;
    rx_state_t             state_next;
    logic                  ack_q;
    logic                  wr_en;
    logic                  rd_en;
    logic                  stall;
    logic                  full;
    logic                  valid;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.req),
        .q     (req_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) req_s_q <= 1'b0;
        else       req_s_q <= req_s;
    end

    // ack is registered from the next state so it rises on the capture edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ack_q <= 1'b0;
        end else begin
            state <= state_next;
            ack_q <= (state_next == ACKED);
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:     state_next = (req_s && !full) ? ACKED : IDLE;
            ACKED:    state_next = req_s ? ACKED : WAIT_LOW;
            WAIT_LOW: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_en = 1'b0;
        stall = 1'b0;
        case (state)
            IDLE: begin
                wr_en = req_s && !full;
                stall = req_s && full;
            end
            default: ;
        endcase
    end

    // Full uses the pre-read count, so a same-cycle read only frees space for the next cycle.
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign valid = (count != '0);
    assign rd_en = valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= bus.input_rx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rx_pulse   = req_s && !req_s_q;
    assign bus.stall      = stall;
    assign bus.out_valid  = valid;
    assign bus.out_data   = valid ? mem[rd_ptr] : '0;
    assign bus.fifo_count = count;

endmodule
